// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the MEM-stage data-memory access unit.
//   * MIPS load/store opcode constants (instruction bits [31:26])
//   * FSM state enum, access-size enum and decoded-access struct
//   * byte-enable width of the data-memory bus
//   * decodeOp: opcode -> size/sign; isMisaligned: alignment rule
//     (isMisaligned is only called when MEM_ALIGN_CHECK_EN is defined)
package mem_pkg;

  localparam int BE_WIDTH = 4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } memState_t;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } accessSize_t;

  typedef struct packed {
    accessSize_t size;
    logic        signExt;
  } accessDecode_t;

  // Unknown opcodes fall through to a word access.
  function automatic accessDecode_t decodeOp(input logic [5:0] op);
    accessDecode_t d;
    d.size    = SIZE_WORD;
    d.signExt = 1'b0;
    case (op)
      OP_LB:        begin d.size = SIZE_BYTE; d.signExt = 1'b1; end
      OP_LBU,
      OP_SB:        d.size = SIZE_BYTE;
      OP_LH:        begin d.size = SIZE_HALF; d.signExt = 1'b1; end
      OP_LHU,
      OP_SH:        d.size = SIZE_HALF;
      default:      d.size = SIZE_WORD;
    endcase
    return d;
  endfunction

  // Only the architected halfword/word opcodes are alignment-checked.
  function automatic logic isMisaligned(input logic [5:0] op,
                                        input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = addrLo[0];
      OP_LW, OP_SW:         bad = |addrLo;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational byte-lane steering (little-endian).
// Store side (request-time inputs):
//   storeSize, storeAddrLo, storeData -> storeWData (replicated), storeBe
// Load side (captured access + memory response):
//   loadSize, loadSigned, loadAddrLo, loadRaw -> loadData (aligned, extended)
module mem_lane_align
  import mem_pkg::*;
(
  input  accessSize_t         storeSize,
  input  logic [1:0]          storeAddrLo,
  input  logic [31:0]         storeData,
  output logic [31:0]         storeWData,
  output logic [BE_WIDTH-1:0] storeBe,
  input  accessSize_t         loadSize,
  input  logic                loadSigned,
  input  logic [1:0]          loadAddrLo,
  input  logic [31:0]         loadRaw,
  output logic [31:0]         loadData
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Halfword lane ignores addr[0]; a word always uses lane 0.
  assign laneByte = loadRaw[{loadAddrLo, 3'b000} +: 8];
  assign laneHalf = loadRaw[{loadAddrLo[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    storeWData = storeData;
    storeBe    = '1;
    case (storeSize)
      SIZE_BYTE: begin
        storeWData = {4{storeData[7:0]}};
        storeBe    = BE_WIDTH'(1) << storeAddrLo;
      end
      SIZE_HALF: begin
        storeWData = {2{storeData[15:0]}};
        storeBe    = storeAddrLo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    loadData = loadRaw;
    case (loadSize)
      SIZE_BYTE: loadData = {{24{loadSigned & laneByte[7]}}, laneByte};
      SIZE_HALF: loadData = {{16{loadSigned & laneHalf[15]}}, laneHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit driving a req/ack data memory.
// Parameter MAX_WAIT: BUSY cycles to wait for D_Ack before aborting.
// Optional feature: define MEM_ALIGN_CHECK_EN to abort misaligned
// halfword/word accesses without issuing a memory request.
// Ports:
//   Clock, Reset (synchronous, active-high)
//   MEM_MemRead, MEM_MemWrite, MEM_ALUOut, MEM_RtData, MEM_Instruction
//     - pipeline request (opcode in MEM_Instruction[31:26])
//   Mem_ReadData - aligned/extended load result (0 for writes/aborts)
//   Mem_Stall    - combinational pipeline hold
//   Mem_Error    - one-cycle abort pulse, high in DONE
//   D_Req, D_We, D_Addr, D_WData, D_BE - memory request bus (registered)
//   D_Ack, D_RData - memory response
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  input  logic [31:0]         MEM_ALUOut,
  input  logic [31:0]         MEM_RtData,
  input  logic [31:0]         MEM_Instruction,
  output logic [31:0]         Mem_ReadData,
  output logic                Mem_Stall,
  output logic                Mem_Error,
  output logic                D_Req,
  output logic                D_We,
  output logic [31:0]         D_Addr,
  output logic [31:0]         D_WData,
  output logic [BE_WIDTH-1:0] D_BE,
  input  logic                D_Ack,
  input  logic [31:0]         D_RData
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  memState_t     state, stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic          memReq;
  logic          alignFault;
  logic          timeout;
  accessDecode_t reqDec;

  // Access captured at request time, used when D_Ack returns.
  accessSize_t   capSize;
  logic          capSigned;
  logic [1:0]    capAddrLo;
  logic          capWrite;

  logic [31:0]         reqWData;
  logic [BE_WIDTH-1:0] reqBe;
  logic [31:0]         loadData;
  logic                unusedInstr;

  assign memReq      = MEM_MemRead | MEM_MemWrite;
  assign reqDec      = decodeOp(MEM_Instruction[31:26]);
  assign unusedInstr = ^MEM_Instruction[25:0];
  assign timeout     = (state == BUSY) && !D_Ack &&
                       (waitCnt == CNT_W'(MAX_WAIT - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign alignFault = isMisaligned(MEM_Instruction[31:26], MEM_ALUOut[1:0]);
`else
  assign alignFault = 1'b0;
`endif

  mem_lane_align uLaneAlign (
    .storeSize  (reqDec.size),
    .storeAddrLo(MEM_ALUOut[1:0]),
    .storeData  (MEM_RtData),
    .storeWData (reqWData),
    .storeBe    (reqBe),
    .loadSize   (capSize),
    .loadSigned (capSigned),
    .loadAddrLo (capAddrLo),
    .loadRaw    (D_RData),
    .loadData   (loadData)
  );

  assign Mem_Stall = (state == BUSY) || ((state == IDLE) && memReq);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memReq) stateNext = alignFault ? DONE : BUSY;
      BUSY:    if (D_Ack || timeout) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      D_Req        <= 1'b0;
      D_We         <= 1'b0;
      D_Addr       <= '0;
      D_WData      <= '0;
      D_BE         <= '0;
      Mem_ReadData <= '0;
      Mem_Error    <= 1'b0;
      waitCnt      <= '0;
      capSize      <= SIZE_WORD;
      capSigned    <= 1'b0;
      capAddrLo    <= '0;
      capWrite     <= 1'b0;
    end else begin
      Mem_Error <= 1'b0;
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (memReq) begin
            if (alignFault) begin
              Mem_Error    <= 1'b1;
              Mem_ReadData <= '0;
            end else begin
              // A simultaneous read+write is performed as the write.
              D_Req     <= 1'b1;
              D_We      <= MEM_MemWrite;
              D_Addr    <= {MEM_ALUOut[31:2], 2'b00};
              D_WData   <= MEM_MemWrite ? reqWData : '0;
              D_BE      <= MEM_MemWrite ? reqBe : '1;
              capSize   <= reqDec.size;
              capSigned <= reqDec.signExt;
              capAddrLo <= MEM_ALUOut[1:0];
              capWrite  <= MEM_MemWrite;
            end
          end
        end
        BUSY: begin
          if (D_Ack) begin
            D_Req        <= 1'b0;
            Mem_ReadData <= capWrite ? '0 : loadData;
          end else if (timeout) begin
            D_Req        <= 1'b0;
            Mem_Error    <= 1'b1;
            Mem_ReadData <= '0;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- self-checking bench for mem_access_unit.
// Directed cases plus randomized accesses compared with a behavioural
// model computed from the lane/extension rules with plain arithmetic.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 64;

  localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LW = 6'h23, LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25, SB  = 6'h28, SH = 6'h29, SW  = 6'h2B;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        MEM_MemRead = 1'b0;
  logic        MEM_MemWrite = 1'b0;
  logic [31:0] MEM_ALUOut = '0;
  logic [31:0] MEM_RtData = '0;
  logic [31:0] MEM_Instruction = '0;
  logic [31:0] Mem_ReadData;
  logic        Mem_Stall;
  logic        Mem_Error;
  logic        D_Req;
  logic        D_We;
  logic [31:0] D_Addr;
  logic [31:0] D_WData;
  logic [3:0]  D_BE;
  logic        D_Ack = 1'b0;
  logic [31:0] D_RData = '0;

  int compared   = 0;
  int mismatched = 0;

  mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_MemWrite   (MEM_MemWrite),
    .MEM_ALUOut     (MEM_ALUOut),
    .MEM_RtData     (MEM_RtData),
    .MEM_Instruction(MEM_Instruction),
    .Mem_ReadData   (Mem_ReadData),
    .Mem_Stall      (Mem_Stall),
    .Mem_Error      (Mem_Error),
    .D_Req          (D_Req),
    .D_We           (D_We),
    .D_Addr         (D_Addr),
    .D_WData        (D_WData),
    .D_BE           (D_BE),
    .D_Ack          (D_Ack),
    .D_RData        (D_RData)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: size from opcode, lanes from address arithmetic.
  task automatic model(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [31:0] rd,
                       input bit wr, output logic [3:0] be,
                       output logic [31:0] wdata, output logic [31:0] rdata,
                       output bit misaligned);
    int size;      // bytes
    bit sgn;
    int lane;
    logic [31:0] v;
    size = 4;
    sgn  = 0;
    if (op == LB || op == LBU || op == SB) size = 1;
    if (op == LH || op == LHU || op == SH) size = 2;
    if (op == LB || op == LH) sgn = 1;
    misaligned = 0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == LH || op == LHU || op == SH) && (addr % 2 != 0)) misaligned = 1;
    if ((op == LW || op == SW) && (addr % 4 != 0)) misaligned = 1;
`endif
    be = 4'b1111; wdata = rt; rdata = rd;
    if (size == 1) begin
      lane = int'(addr % 4);
      if (wr) begin
        be    = 4'(1 << lane);
        wdata = (rt & 32'hFF) * 32'h0101_0101;
      end else begin
        v = (rd >> (8 * lane)) & 32'hFF;
        if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        rdata = v;
      end
    end else if (size == 2) begin
      lane = int'((addr / 2) % 2);
      if (wr) begin
        be    = (lane == 1) ? 4'b1100 : 4'b0011;
        wdata = (rt & 32'hFFFF) * 32'h0001_0001;
      end else begin
        v = (rd >> (16 * lane)) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        rdata = v;
      end
    end
    if (wr) rdata = 32'h0;
  endtask

  // One full access; ackDelay = BUSY cycle index that sees D_Ack, <0 = never.
  task automatic runAccess(input string tag, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rd, input bit rdReq,
                           input bit wrReq, input int ackDelay);
    logic [3:0]  expBe;
    logic [31:0] expWData, expRead;
    bit          mis, done, stable;
    int          busy, stalls;
    logic [31:0] a0, w0;
    logic [3:0]  b0;

    model(op, addr, rt, rd, wrReq, expBe, expWData, expRead, mis);
    if (ackDelay < 0) expRead = 32'h0;

    @(negedge Clock);
    MEM_MemRead     = rdReq;
    MEM_MemWrite    = wrReq;
    MEM_ALUOut      = addr;
    MEM_RtData      = rt;
    MEM_Instruction = {op, 26'($urandom)};
    #1 check({tag, "_stall_idle"}, 32'(Mem_Stall), 32'h1);
    stalls = 1;

    @(posedge Clock);
    #1;
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;

    if (mis) begin
      @(negedge Clock);
      check({tag, "_mis_stall"}, 32'(Mem_Stall), 32'h0);
      check({tag, "_mis_err"}, 32'(Mem_Error), 32'h1);
      check({tag, "_mis_req"}, 32'(D_Req), 32'h0);
      check({tag, "_mis_rdata"}, Mem_ReadData, 32'h0);
      @(negedge Clock);
      check({tag, "_mis_err_drop"}, 32'(Mem_Error), 32'h0);
      return;
    end

    busy = 0; done = 0; stable = 1;
    a0 = '0; w0 = '0; b0 = '0;
    while (!done && busy <= MAX_WAIT + 4) begin
      @(negedge Clock);
      if (!Mem_Stall) begin
        done = 1;
      end else begin
        if (busy == 0) begin
          check({tag, "_req"}, 32'(D_Req), 32'h1);
          check({tag, "_we"}, 32'(D_We), 32'(wrReq));
          check({tag, "_addr"}, D_Addr, addr & 32'hFFFF_FFFC);
          check({tag, "_be"}, 32'(D_BE), 32'(expBe));
          if (wrReq) check({tag, "_wdata"}, D_WData, expWData);
          a0 = D_Addr; w0 = D_WData; b0 = D_BE;
        end else if (D_Req !== 1'b1 || D_Addr !== a0 || D_WData !== w0 || D_BE !== b0) begin
          stable = 0;
        end
        stalls++;
        D_Ack   = (busy == ackDelay);
        D_RData = (busy == ackDelay) ? rd : $urandom;
        busy++;
      end
    end
    D_Ack   = 1'b0;
    D_RData = $urandom;
    check({tag, "_completed"}, 32'(done), 32'h1);
    check({tag, "_stable"}, 32'(stable), 32'h1);
    check({tag, "_stalls"}, stalls, (ackDelay < 0) ? MAX_WAIT + 1 : ackDelay + 2);
    check({tag, "_rdata"}, Mem_ReadData, expRead);
    check({tag, "_err"}, 32'(Mem_Error), (ackDelay < 0) ? 32'h1 : 32'h0);
    check({tag, "_req_drop"}, 32'(D_Req), 32'h0);
    @(negedge Clock);
    check({tag, "_err_once"}, 32'(Mem_Error), 32'h0);
    check({tag, "_idle_stall"}, 32'(Mem_Stall), 32'h0);
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    int         sel, dly;
    bit         rdq, wrq;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00};

    // Reset state
    repeat (2) @(negedge Clock);
    check("rst_req", 32'(D_Req), 32'h0);
    check("rst_we", 32'(D_We), 32'h0);
    check("rst_addr", D_Addr, 32'h0);
    check("rst_wdata", D_WData, 32'h0);
    check("rst_be", 32'(D_BE), 32'h0);
    check("rst_rdata", Mem_ReadData, 32'h0);
    check("rst_err", 32'(Mem_Error), 32'h0);
    check("rst_stall", 32'(Mem_Stall), 32'h0);
    Reset = 1'b0;

    // Directed cases
    runAccess("lw100", LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
    runAccess("lb103", LB, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 0);
    runAccess("lbu103", LBU, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 2);

    // Reset in the middle of BUSY, then a late D_Ack
    @(negedge Clock);
    MEM_MemRead = 1'b1; MEM_Instruction = {LW, 26'h0}; MEM_ALUOut = 32'h300;
    @(posedge Clock);
    #1 MEM_MemRead = 1'b0;
    @(negedge Clock);
    check("rstbusy_req_before", 32'(D_Req), 32'h1);
    Reset = 1'b1;
    @(negedge Clock);
    check("rstbusy_req", 32'(D_Req), 32'h0);
    check("rstbusy_stall", 32'(Mem_Stall), 32'h0);
    check("rstbusy_rdata", Mem_ReadData, 32'h0);
    Reset = 1'b0; D_Ack = 1'b1; D_RData = 32'h1234_5678;
    @(negedge Clock);
    D_Ack = 1'b0;
    check("lateack_req", 32'(D_Req), 32'h0);
    check("lateack_stall", 32'(Mem_Stall), 32'h0);
    check("lateack_rdata", Mem_ReadData, 32'h0);

    runAccess("sh202", SH, 32'h202, 32'h1234_ABCD, 32'h0, 0, 1, 0);
    runAccess("rdwr_both", LW, 32'h40C, 32'hCAFE_F00D, 32'h5555_AAAA, 1, 1, 1);
    runAccess("timeout", LW, 32'h500, 32'h0, 32'h0, 1, 0, -1);
    runAccess("lw101", LW, 32'h101, 32'h0, 32'h0BAD_F00D, 1, 0, 0);
    runAccess("lhu_hi", LHU, 32'h602, 32'h0, 32'h8001_7FFE, 1, 0, 0);

    // D_Ack while IDLE must not start anything
    @(negedge Clock);
    D_Ack = 1'b1;
    @(negedge Clock);
    D_Ack = 1'b0;
    check("idleack_req", 32'(D_Req), 32'h0);
    check("idleack_stall", 32'(Mem_Stall), 32'h0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      op  = ops[$urandom_range(0, 8)];
      sel = $urandom_range(0, 3);
      rdq = (sel != 1);
      wrq = (sel == 1 || sel == 2);
      dly = $urandom_range(0, 5);
      runAccess($sformatf("rnd%0d", i), op, $urandom, $urandom, $urandom, rdq, wrq, dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
